re_control_multi: RTL

Parametrised readout controller for the pixel-array front end. It sequences erase, exposure and a row-by-row readout over N_ROWS row-enable lines, and drives the ADC strobe for each row. It owns a saturating exposure-time register with push-button-style adjustment, a continuous (free-running) mode, an abort input and frame status outputs. It sits between the user/control inputs and the pixel array/ADC, and replaces the fixed two-row controller.

---
 rtl/re_control_multi.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/re_control_multi.sv
// re_control_multi: readout controller for the pixel-array front end.
// Runs erase (IDLE), exposure (EXPOSE) and a row-by-row readout (READ).
// During READ each of N_ROWS rows gets a slot of ADC_CYCLES+2 cycles.
// It also owns a saturating exposure-time register with edge-triggered
// +/- buttons, supports continuous restart, and accepts a synchronous abort.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_init         start a frame (level, sampled in IDLE)
//   i_cont         continuous mode: restart frames automatically from IDLE
//   i_abort        abort the current frame / block a start in IDLE
//   i_ex_increase  exposure +1 on rising edge (IDLE only)
//   i_ex_decrease  exposure -1 on rising edge (IDLE only)
//   o_nre          active-low row enables, bit r selects row r
//   o_adc          ADC conversion strobe
//   o_expose       exposure active
//   o_erase        pixel erase, high while idle
//   o_busy         frame in progress (EXPOSE or READ)
//   o_frame_done   one-cycle pulse on normal frame completion
//   o_ex_time      current exposure-time register
module re_control_multi #(
  parameter int unsigned N_ROWS     = 2,
  parameter int unsigned TIME_W     = 5,
  parameter int unsigned EX_MIN     = 2,
  parameter int unsigned EX_MAX     = 30,
  parameter int unsigned EX_DEFAULT = 2,
  parameter int unsigned TICK       = 1,
  parameter int unsigned ADC_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_init,
  input  logic              i_cont,
  input  logic              i_abort,
  input  logic              i_ex_increase,
  input  logic              i_ex_decrease,
  output logic [N_ROWS-1:0] o_nre,
  output logic              o_adc,
  output logic              o_expose,
  output logic              o_erase,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [TIME_W-1:0] o_ex_time
);

  localparam int unsigned SLOT    = ADC_CYCLES + 2;
  localparam int unsigned SLOT_W  = $clog2(SLOT);
  localparam int unsigned ROW_W   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int unsigned TIMER_W = $clog2(EX_MAX * TICK + 1);

  localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(N_ROWS - 1);
  localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(SLOT - 1);
  localparam logic [SLOT_W-1:0]  ADC_LAST  = SLOT_W'(ADC_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [TIME_W-1:0]  EXT_MIN   = TIME_W'(EX_MIN);
  localparam logic [TIME_W-1:0]  EXT_MAX   = TIME_W'(EX_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPOSE = 2'd1,
    S_READ   = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [TIMER_W-1:0]  r_timer, w_timer_nxt;
  logic [ROW_W-1:0]    r_row,   w_row_nxt;
  logic [SLOT_W-1:0]   r_slot,  w_slot_nxt;
  logic                w_frame_end;
  logic                w_start;
  logic [TIMER_W-1:0]  w_load;

  logic [TIME_W-1:0]   r_ex_time;
  logic                r_inc_q, r_inc_qq, r_dec_q, r_dec_qq;
  logic                w_inc_rise, w_dec_rise, w_step_ok;

  logic [N_ROWS-1:0]   w_nre_nxt;
  logic                w_adc_nxt, w_expose_nxt, w_erase_nxt, w_busy_nxt, w_done_nxt;

  // Abort has priority over both start sources.
  assign w_start = (r_state == S_IDLE) && !i_abort && (i_init || i_cont);

  // Exposure length is latched here while idle, so later edits miss this frame.
  assign w_load = TIMER_W'(r_ex_time) * TIMER_W'(TICK);

  // State and sequencing counters.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_row   <= '0;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_row   <= w_row_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_row_nxt   = r_row;
    w_slot_nxt  = r_slot;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = w_load;
        w_row_nxt   = '0;
        w_slot_nxt  = '0;
        if (w_start) w_state_nxt = S_EXPOSE;
      end
      S_EXPOSE: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_timer <= TIMER_ONE) begin
          w_state_nxt = S_READ;
          w_row_nxt   = '0;
          w_slot_nxt  = '0;
        end else begin
          w_timer_nxt = r_timer - TIMER_ONE;
        end
      end
      S_READ: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_slot == LAST_SLOT) begin
          w_slot_nxt = '0;
          if (r_row == LAST_ROW) begin
            w_state_nxt = S_IDLE;
            w_frame_end = 1'b1;
          end else begin
            w_row_nxt = r_row + ROW_W'(1);
          end
        end else begin
          w_slot_nxt = r_slot + SLOT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    w_nre_nxt    = '1;
    w_adc_nxt    = 1'b0;
    w_expose_nxt = 1'b0;
    w_erase_nxt  = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    case (w_state_nxt)
      S_IDLE: begin
        w_erase_nxt = 1'b1;
        w_done_nxt  = w_frame_end;
      end
      S_EXPOSE: begin
        w_expose_nxt = 1'b1;
        w_busy_nxt   = 1'b1;
      end
      S_READ: begin
        w_busy_nxt = 1'b1;
        w_nre_nxt  = ~(N_ROWS'(1) << w_row_nxt);
        w_adc_nxt  = (w_slot_nxt != '0) && (w_slot_nxt <= ADC_LAST);
      end
      default: begin
        w_erase_nxt = 1'b1;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_nre        <= '1;
      o_adc        <= 1'b0;
      o_expose     <= 1'b0;
      o_erase      <= 1'b1;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_nre        <= w_nre_nxt;
      o_adc        <= w_adc_nxt;
      o_expose     <= w_expose_nxt;
      o_erase      <= w_erase_nxt;
      o_busy       <= w_busy_nxt;
      o_frame_done <= w_done_nxt;
    end
  end

  // Button edge detect; edges outside an idle, non-starting cycle are dropped.
  assign w_inc_rise = r_inc_q && !r_inc_qq;
  assign w_dec_rise = r_dec_q && !r_dec_qq;
  assign w_step_ok  = (r_state == S_IDLE) && !w_start;

  // Saturating exposure-time register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_inc_q   <= 1'b0;
      r_inc_qq  <= 1'b0;
      r_dec_q   <= 1'b0;
      r_dec_qq  <= 1'b0;
      r_ex_time <= TIME_W'(EX_DEFAULT);
    end else begin
      r_inc_q  <= i_ex_increase;
      r_inc_qq <= r_inc_q;
      r_dec_q  <= i_ex_decrease;
      r_dec_qq <= r_dec_q;
      if (w_step_ok) begin
        if (w_inc_rise && !w_dec_rise && (r_ex_time < EXT_MAX))
          r_ex_time <= r_ex_time + TIME_W'(1);
        else if (w_dec_rise && !w_inc_rise && (r_ex_time > EXT_MIN))
          r_ex_time <= r_ex_time - TIME_W'(1);
      end
    end
  end

  assign o_ex_time = r_ex_time;

endmodule
